// File: rtl/mmio_rd_tracker.sv
// mmio_rd_tracker: in-order FIFO of host MMIO reads outstanding to the AFU,
// with one age timer on the head entry. Drives the fake-completion handshake
// with tx_filter once the head times out or traffic is blocked.

package mmio_rd_tracker_pkg;
    typedef struct packed {
        logic [9:0]  tag;
        logic [15:0] requester_id;
        logic [63:0] addr;
        logic        dw0_len;
    } t_mmio_timeout_hdr_info;
endpackage

module mmio_rd_tracker
    import mmio_rd_tracker_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_afu_softreset,
    input  logic                      i_clear_errors,
    input  logic                      i_block_traffic,
    input  logic                      i_rx_rd_valid,
    input  t_mmio_timeout_hdr_info    i_rx_rd_info,
    input  logic                      i_tx_cpl_valid,
    input  logic [9:0]                i_tx_cpl_tag,
    input  logic                      i_mmio_rd_rsp_ack,
    output logic                      o_mmio_timeout_err,
    output logic                      o_next_pending_mmio_rdy,
    output logic                      o_flush_mmio_rsp_queue_complete,
    output t_mmio_timeout_hdr_info    o_mmio_timeout_info,
    output logic [$clog2(DEPTH):0]    o_pending_count,
    output logic                      o_overflow_err,
    output logic                      o_unexpected_cpl
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_WAIT_ACK   = 2'd1,
        ST_FLUSH_NEXT = 2'd2,
        ST_BLOCKED    = 2'd3
    } state_t;

    state_t                 state_r;
    t_mmio_timeout_hdr_info mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [TW-1:0]          timer_r;
    logic                   softreset_q_r;
    logic                   err_r;
    logic                   rdy_r;
    logic                   fc_r;
    logic                   ovf_r;
    logic                   unx_r;

    logic                   empty_s;
    logic                   full_s;
    logic                   head_match_s;
    logic                   cpl_hit_s;
    logic                   cpl_bad_s;
    logic                   ack_pop_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   ovf_s;
    logic                   timeout_s;
    logic                   sr_fall_s;

    assign empty_s      = (count_r == CW'(0));
    assign full_s       = (count_r == CW'(DEPTH));
    assign head_match_s = !empty_s && (i_tx_cpl_tag == mem_r[rd_ptr_r].tag);
    // Completions are only meaningful while the tracker is in normal operation.
    assign cpl_hit_s    = (state_r == ST_NORMAL) && i_tx_cpl_valid && head_match_s;
    assign cpl_bad_s    = (state_r == ST_NORMAL) && i_tx_cpl_valid && !head_match_s;
    assign ack_pop_s    = (state_r == ST_WAIT_ACK) && i_mmio_rd_rsp_ack;
    assign pop_s        = cpl_hit_s || ack_pop_s;
    // A full FIFO still accepts a read when the head leaves in the same cycle.
    assign push_s       = i_rx_rd_valid && (!full_s || pop_s);
    assign ovf_s        = i_rx_rd_valid && full_s && !pop_s;
    // A head that is being completed this very cycle has not timed out.
    assign timeout_s    = (state_r == ST_NORMAL) && !empty_s && (timer_r == TMAX) && !cpl_hit_s;
    assign sr_fall_s    = softreset_q_r && !i_afu_softreset;

    assign o_mmio_timeout_info             = empty_s ? '0 : mem_r[rd_ptr_r];
    assign o_pending_count                 = count_r;
    assign o_mmio_timeout_err              = err_r;
    assign o_next_pending_mmio_rdy         = rdy_r;
    assign o_flush_mmio_rsp_queue_complete = fc_r;
    assign o_overflow_err                  = ovf_r;
    assign o_unexpected_cpl                = unx_r;

    // Capture each accepted read into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_rx_rd_info;
        end
    end

    // FIFO pointers, occupancy, head-age timer and softreset edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            timer_r       <= '0;
            softreset_q_r <= 1'b0;
        end else begin
            softreset_q_r <= i_afu_softreset;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s || empty_s) begin
                timer_r <= '0;
            end else if ((state_r == ST_NORMAL) && (timer_r != TMAX)) begin
                timer_r <= timer_r + TW'(1);
            end
        end
    end

    // Error/flush state machine and its registered single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_NORMAL;
            err_r   <= 1'b0;
            rdy_r   <= 1'b0;
            fc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unx_r   <= 1'b0;
        end else begin
            err_r <= timeout_s;
            ovf_r <= ovf_s;
            unx_r <= cpl_bad_s;
            rdy_r <= 1'b0;
            fc_r  <= 1'b0;
            case (state_r)
                ST_NORMAL: begin
                    if (timeout_s) begin
                        state_r <= ST_WAIT_ACK;
                    end else if (i_block_traffic) begin
                        state_r <= ST_FLUSH_NEXT;
                    end
                end
                ST_WAIT_ACK: begin
                    if (i_mmio_rd_rsp_ack) begin
                        state_r <= ST_FLUSH_NEXT;
                    end
                end
                ST_FLUSH_NEXT: begin
                    if (!empty_s) begin
                        rdy_r   <= 1'b1;
                        state_r <= ST_WAIT_ACK;
                    end else begin
                        fc_r    <= 1'b1;
                        state_r <= ST_BLOCKED;
                    end
                end
                ST_BLOCKED: begin
                    // Leaving wins over a newly arrived read; NORMAL handles it.
                    if (i_clear_errors || sr_fall_s) begin
                        state_r <= ST_NORMAL;
                    end else if (!empty_s) begin
                        rdy_r   <= 1'b1;
                        state_r <= ST_WAIT_ACK;
                    end
                end
                default: begin
                    state_r <= ST_NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_rd_tracker.sv
// Self-checking bench for mmio_rd_tracker: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.

module tb_mmio_rd_tracker;
    import mmio_rd_tracker_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic softreset = 1'b0;
    logic clear_errors = 1'b0;
    logic block_traffic = 1'b0;
    logic rx_v = 1'b0;
    t_mmio_timeout_hdr_info rx_info = '0;
    logic cpl_v = 1'b0;
    logic [9:0] cpl_tag = 10'd0;
    logic ack = 1'b0;

    logic timeout_err, next_rdy, flush_done, overflow_err, unexpected_cpl;
    t_mmio_timeout_hdr_info info;
    logic [CW-1:0] pending_count;

    mmio_rd_tracker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .i_afu_softreset                 (softreset),
        .i_clear_errors                  (clear_errors),
        .i_block_traffic                 (block_traffic),
        .i_rx_rd_valid                   (rx_v),
        .i_rx_rd_info                    (rx_info),
        .i_tx_cpl_valid                  (cpl_v),
        .i_tx_cpl_tag                    (cpl_tag),
        .i_mmio_rd_rsp_ack               (ack),
        .o_mmio_timeout_err              (timeout_err),
        .o_next_pending_mmio_rdy         (next_rdy),
        .o_flush_mmio_rsp_queue_complete (flush_done),
        .o_mmio_timeout_info             (info),
        .o_pending_count                 (pending_count),
        .o_overflow_err                  (overflow_err),
        .o_unexpected_cpl                (unexpected_cpl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding reads in arrival order plus the tracker's mode.
    // mode: 0 normal, 1 awaiting ack, 2 presenting next, 3 blocked
    t_mmio_timeout_hdr_info q[$];
    int age;
    int mode;
    bit sr_prev;
    bit e_err, e_rdy, e_fc, e_ovf, e_unx;
    int ack_cd;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic t_mmio_timeout_hdr_info mk_info(input logic [9:0] tag);
        t_mmio_timeout_hdr_info r;
        r.tag          = tag;
        r.requester_id = 16'($urandom);
        r.addr         = {32'($urandom), 32'($urandom)};
        r.dw0_len      = 1'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        age = 0; mode = 0; sr_prev = 1'b0; ack_cd = 0;
        e_err = 1'b0; e_rdy = 1'b0; e_fc = 1'b0; e_ovf = 1'b0; e_unx = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_eval();
        bit nonempty;
        bit head_match;
        bit hit;
        bit pop;
        bit full;
        bit fall;
        int old_mode;
        nonempty   = (q.size() != 0);
        head_match = nonempty && (cpl_tag == q[0].tag);
        hit        = (mode == 0) && cpl_v && head_match;
        pop        = hit || ((mode == 1) && ack);
        full       = (q.size() == DEPTH);
        fall       = sr_prev && !softreset;
        old_mode   = mode;
        e_err = (mode == 0) && nonempty && (age == TMO - 1) && !hit;
        e_unx = (mode == 0) && cpl_v && !head_match;
        e_ovf = rx_v && full && !pop;
        e_rdy = 1'b0;
        e_fc  = 1'b0;
        if (mode == 0) begin
            if (e_err) mode = 1;
            else if (block_traffic) mode = 2;
        end else if (mode == 1) begin
            if (ack) mode = 2;
        end else if (mode == 2) begin
            if (nonempty) begin e_rdy = 1'b1; mode = 1; end
            else begin e_fc = 1'b1; mode = 3; end
        end else begin
            if (clear_errors || fall) mode = 0;
            else if (nonempty) begin e_rdy = 1'b1; mode = 1; end
        end
        if (pop || !nonempty) age = 0;
        else if (old_mode == 0 && age < TMO - 1) age++;
        if (pop) void'(q.pop_front());
        if (rx_v && (!full || pop)) q.push_back(rx_info);
        sr_prev = softreset;
    endtask

    task automatic compare_all();
        t_mmio_timeout_hdr_info exp_info;
        exp_info = (q.size() != 0) ? q[0] : '0;
        check("count", 128'(pending_count), 128'(q.size()));
        check("info", 128'(info), 128'(exp_info));
        check("timeout_err", 128'(timeout_err), 128'(e_err));
        check("next_rdy", 128'(next_rdy), 128'(e_rdy));
        check("flush_complete", 128'(flush_done), 128'(e_fc));
        check("overflow_err", 128'(overflow_err), 128'(e_ovf));
        check("unexpected_cpl", 128'(unexpected_cpl), 128'(e_unx));
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        rx_v = 1'b0; cpl_v = 1'b0; ack = 1'b0; block_traffic = 1'b0; clear_errors = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [9:0] tag);
        rx_v = 1'b1; rx_info = mk_info(tag);
        tick();
        rx_v = 1'b0;
    endtask

    task automatic cpl(input logic [9:0] tag);
        cpl_v = 1'b1; cpl_tag = tag;
        tick();
        cpl_v = 1'b0;
    endtask

    // tx_filter answers two cycles after the pulse it saw.
    task automatic ack_after();
        idle(1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic clear();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_count", 128'(pending_count), 128'(0));
        check("reset_info", 128'(info), 128'(0));
        check("reset_pulses", 128'({timeout_err, next_rdy, flush_done, overflow_err, unexpected_cpl}), 128'(0));
        rst_n = 1'b1;
        idle(2);

        // 1: in-order completions drain the FIFO
        push(10'd1); push(10'd2); push(10'd3);
        check("t1_count3", 128'(pending_count), 128'(3));
        cpl(10'd1); cpl(10'd2); cpl(10'd3);
        check("t1_count0", 128'(pending_count), 128'(0));
        idle(2);

        // 2: lone read times out exactly TMO cycles after its push
        push(10'd5);
        for (int i = 1; i < TMO; i++) tick();
        check("t2_no_early_err", 128'(timeout_err), 128'(0));
        tick();
        check("t2_err", 128'(timeout_err), 128'(1));
        check("t2_tag", 128'(info.tag), 128'(5));
        ack_after();
        tick();
        check("t2_flush_done", 128'(flush_done), 128'(1));
        check("t2_count0", 128'(pending_count), 128'(0));

        // 4: new read while blocked is presented immediately
        push(10'd4);
        tick();
        check("t4_rdy", 128'(next_rdy), 128'(1));
        check("t4_tag", 128'(info.tag), 128'(4));
        ack_after();
        tick();
        check("t4_flush_done", 128'(flush_done), 128'(1));
        check("t4_count0", 128'(pending_count), 128'(0));
        clear();
        push(10'd6);
        for (int i = 1; i < TMO; i++) tick();
        tick();
        check("t4_err_again", 128'(timeout_err), 128'(1));
        ack_after();
        tick();
        clear();

        // 3: three reads, head times out, the rest are presented in order
        push(10'd7); push(10'd8); push(10'd9);
        begin
            int n;
            n = 0;
            while (!timeout_err && n < TMO + 10) begin
                tick();
                n++;
            end
            check("t3_err_seen", 128'(timeout_err), 128'(1));
        end
        check("t3_tag7", 128'(info.tag), 128'(7));
        ack_after(); tick();
        check("t3_rdy8", 128'(next_rdy), 128'(1));
        check("t3_tag8", 128'(info.tag), 128'(8));
        ack_after(); tick();
        check("t3_rdy9", 128'(next_rdy), 128'(1));
        check("t3_tag9", 128'(info.tag), 128'(9));
        ack_after(); tick();
        check("t3_flush_done", 128'(flush_done), 128'(1));
        check("t3_count0", 128'(pending_count), 128'(0));
        clear();

        // 5: overflow and unexpected completion
        for (int i = 0; i <= DEPTH; i++) push(10'(16 + i));
        check("t5_ovf", 128'(overflow_err), 128'(1));
        check("t5_full", 128'(pending_count), 128'(DEPTH));
        cpl(10'd999);
        check("t5_unx", 128'(unexpected_cpl), 128'(1));
        check("t5_count_kept", 128'(pending_count), 128'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cpl(10'(16 + i));
        check("t5_drained", 128'(pending_count), 128'(0));
        cpl(10'd3);
        check("t5_unx_empty", 128'(unexpected_cpl), 128'(1));

        // 6: block_traffic flush of two entries
        push(10'd20); push(10'd21);
        block_traffic = 1'b1; tick(); block_traffic = 1'b0;
        tick();
        check("t6_rdy20", 128'(next_rdy), 128'(1));
        check("t6_tag20", 128'(info.tag), 128'(20));
        ack_after(); tick();
        check("t6_rdy21", 128'(next_rdy), 128'(1));
        check("t6_tag21", 128'(info.tag), 128'(21));
        ack_after(); tick();
        check("t6_flush_done", 128'(flush_done), 128'(1));
        clear();
        // asynchronous reset while waiting for an ack
        push(10'd30);
        block_traffic = 1'b1; tick(); block_traffic = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 128'(pending_count), 128'(0));
        check("t6_rst_info", 128'(info), 128'(0));
        check("t6_rst_pulses", 128'({timeout_err, next_rdy, flush_done, overflow_err, unexpected_cpl}), 128'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic with a tx_filter that acks 2..4 cycles after each pulse
        for (int c = 0; c < 2000; c++) begin
            rx_v = ($urandom_range(0, 3) == 0);
            rx_info = mk_info(10'($urandom));
            cpl_v = 1'b0;
            if (mode == 0 && q.size() != 0 && $urandom_range(0, 2) == 0) begin
                cpl_v = 1'b1; cpl_tag = q[0].tag;
            end else if ($urandom_range(0, 19) == 0) begin
                cpl_v = 1'b1; cpl_tag = 10'($urandom);
            end
            block_traffic = ($urandom_range(0, 199) == 0);
            clear_errors  = (mode == 3) && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) softreset = ~softreset;
            ack = (ack_cd == 1);
            tick();
            if (ack_cd > 0) ack_cd--;
            if (e_err || e_rdy) ack_cd = $urandom_range(2, 4);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
